uart_erisim_hakemi: RTL and testbench
=====================================

UART_ERISIM_HAKEMI -- requirements
Module: uart_erisim_hakemi

Interface
REQ-001 The block SHALL have parameter ONCELIK_SABIT, default 0, meaning 0 = round-robin arbitration, 1 = fixed priority with m0 always winning.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports m0_istek_i and m1_istek_i, input, 1 bit each: request valid; held stable until the matching kabul pulse.
REQ-006 The block SHALL have ports m0_yaz_i and m1_yaz_i, input, 1 bit each: 1 = write, 0 = read.
REQ-007 The block SHALL have ports m0_adres_i and m1_adres_i, input, 32 bits each: register address.
REQ-008 The block SHALL have ports m0_veri_i and m1_veri_i, input, 32 bits each: write data.
REQ-009 The block SHALL have ports m0_kabul_o and m1_kabul_o, output, 1 bit each: one-cycle request-accepted pulse.
REQ-010 The block SHALL have ports m0_bitti_o and m1_bitti_o, output, 1 bit each: one-cycle transaction-complete pulse.
REQ-011 The block SHALL have ports m0_oku_gecerli_o and m1_oku_gecerli_o, output, 1 bit each: read data valid, qualified by bitti.
REQ-012 The block SHALL have ports m0_oku_veri_o and m1_oku_veri_o, output, 32 bits each: read data.
REQ-013 The block SHALL have ports wb_adres_o and wb_veri_o, output, 32 bits each: address and write data forwarded to the UART controller.
REQ-014 The block SHALL have ports wb_gecerli_o and wb_yaz_gecerli_o, output, 1 bit each: controller access strobe and write qualifier.
REQ-015 The block SHALL have ports wb_oku_veri_i, input, 32 bits, and wb_oku_gecerli_i, input, 1 bit: controller response, valid one cycle after the strobe.
REQ-016 The block SHALL have port uart_mesgul_i, input, 1 bit: controller busy; blocks new grants.

Function
REQ-017 The block SHALL implement FSM states BOSTA, VERI and YANIT, with all outputs registered.
REQ-018 BOSTA: if (m0_istek_i | m1_istek_i) & ~uart_mesgul_i, the block SHALL latch the winner's yaz/adres/veri and go to VERI; otherwise it SHALL stay in BOSTA.
REQ-019 VERI (exactly one cycle): wb_gecerli_o=1, wb_yaz_gecerli_o=latched yaz, and the winner's kabul_o=1; next state YANIT.
REQ-020 YANIT (exactly one cycle): the winner's bitti_o=1 and its oku_gecerli_o = ~yaz & wb_oku_gecerli_i; next state BOSTA.
REQ-021 In YANIT, the winner's oku_veri_o SHALL load wb_oku_veri_i only when ~yaz & wb_oku_gecerli_i; otherwise it holds.
REQ-022 Transaction latency: request sampled in BOSTA at cycle T gives kabul at T+1 and bitti at T+2; the next grant is evaluated no earlier than T+3.
REQ-023 Requests present in VERI or YANIT SHALL be ignored until the next BOSTA cycle.
REQ-024 Round-robin: a single requester wins; when both request, the winner is the master not recorded in son_kazanan; son_kazanan updates to the winner on the transition into VERI.
REQ-025 With ONCELIK_SABIT=1, m0 SHALL win every tie; son_kazanan is still maintained.
REQ-026 A read that returns no data (RX buffer empty, wb_oku_gecerli_i=0) SHALL complete with bitti=1, oku_gecerli=0, and oku_veri held.
REQ-027 uart_mesgul_i SHALL be sampled only in BOSTA; its assertion during VERI or YANIT SHALL NOT abort a transaction.
REQ-028 Outside VERI: wb_gecerli_o=0 and wb_yaz_gecerli_o=0; wb_adres_o and wb_veri_o hold their last values.
REQ-029 The non-winning master's kabul_o, bitti_o and oku_gecerli_o SHALL remain 0 for the whole transaction.

Reset
REQ-030 Asserting rst_i=0 SHALL immediately force state BOSTA, son_kazanan=m1 (so m0 wins the first tie), and all outputs and latched request fields to 0.
REQ-031 Reset during VERI or YANIT SHALL abandon the transaction: no bitti pulse after release, and the controller strobe drops at once.
REQ-032 The first grant SHALL occur no earlier than the first rising edge after rst_i deasserts.

Verification
REQ-033 m0 writes adres 0x0, veri 0x00A0_0003 -> kabul at T+1 with wb_gecerli_o=1, wb_yaz_gecerli_o=1, wb_veri_o=0x00A0_0003; bitti at T+2 with m0_oku_gecerli_o=0.
REQ-034 m1 reads adres 0x4 with response 0x0000_000C -> m1_bitti_o=1, m1_oku_gecerli_o=1, m1_oku_veri_o=0x0000_000C at T+2.
REQ-035 Both request continuously from reset for 4 transactions -> grant order m0, m1, m0, m1; with ONCELIK_SABIT=1 -> m0, m0, m0, m0.
REQ-036 m0 reads adres 0x8 with wb_oku_gecerli_i=0 -> m0_bitti_o=1, m0_oku_gecerli_o=0, m0_oku_veri_o unchanged.
REQ-037 uart_mesgul_i=1 for 5 cycles while m1 requests -> no kabul and wb_gecerli_o=0 throughout; kabul 2 cycles after uart_mesgul_i falls.
REQ-038 rst_i pulsed low during VERI -> wb_gecerli_o and kabul drop asynchronously, no bitti follows, and the next tie goes to m0.

Source files
------------

// File: rtl/uart_erisim_hakemi.sv
// rtl/uart_erisim_hakemi.sv - two-master arbiter in front of the UART controller register port
`timescale 1ns/1ps
module uart_erisim_hakemi #(
   parameter bit ONCELIK_SABIT = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_istek_i,
   input  logic        m1_istek_i,
   input  logic        m0_yaz_i,
   input  logic        m1_yaz_i,
   input  logic [31:0] m0_adres_i,
   input  logic [31:0] m1_adres_i,
   input  logic [31:0] m0_veri_i,
   input  logic [31:0] m1_veri_i,
   output logic        m0_kabul_o,
   output logic        m1_kabul_o,
   output logic        m0_bitti_o,
   output logic        m1_bitti_o,
   output logic        m0_oku_gecerli_o,
   output logic        m1_oku_gecerli_o,
   output logic [31:0] m0_oku_veri_o,
   output logic [31:0] m1_oku_veri_o,
   output logic [31:0] wb_adres_o,
   output logic [31:0] wb_veri_o,
   output logic        wb_gecerli_o,
   output logic        wb_yaz_gecerli_o,
   input  logic [31:0] wb_oku_veri_i,
   input  logic        wb_oku_gecerli_i,
   input  logic        uart_mesgul_i
);

   typedef enum logic [1:0] {BOSTA = 2'd0, VERI = 2'd1, YANIT = 2'd2} durum_t;

   durum_t           durum_q, durum_d;
   logic             son_kazanan_q, son_kazanan_d;
   logic             kazanan_q, kazanan_d;
   logic             yaz_q, yaz_d;
   logic [31:0]      wb_adres_q, wb_adres_d;
   logic [31:0]      wb_veri_q, wb_veri_d;
   logic             wb_gecerli_q, wb_gecerli_d;
   logic             wb_yaz_gecerli_q, wb_yaz_gecerli_d;
   logic [1:0]       kabul_q, kabul_d;
   logic [1:0]       bitti_q, bitti_d;
   logic [1:0]       oku_gecerli_q, oku_gecerli_d;
   logic [1:0][31:0] oku_veri_q, oku_veri_d;

   logic             secilen;
   logic             secilen_yaz;
   logic [31:0]      secilen_adres;
   logic [31:0]      secilen_veri;

   // A lone requester always wins; a tie goes to m0 or to whoever did not win last.
   always_comb begin
      secilen = m1_istek_i;
      if (m0_istek_i && m1_istek_i) begin
         secilen = ONCELIK_SABIT ? 1'b0 : ~son_kazanan_q;
      end
      secilen_yaz   = secilen ? m1_yaz_i   : m0_yaz_i;
      secilen_adres = secilen ? m1_adres_i : m0_adres_i;
      secilen_veri  = secilen ? m1_veri_i  : m0_veri_i;
   end

   always_comb begin
      durum_d          = durum_q;
      son_kazanan_d    = son_kazanan_q;
      kazanan_d        = kazanan_q;
      yaz_d            = yaz_q;
      wb_adres_d       = wb_adres_q;
      wb_veri_d        = wb_veri_q;
      wb_gecerli_d     = 1'b0;
      wb_yaz_gecerli_d = 1'b0;
      kabul_d          = 2'b00;
      bitti_d          = 2'b00;
      oku_gecerli_d    = 2'b00;
      oku_veri_d       = oku_veri_q;
      case (durum_q)
         BOSTA: begin
            if ((m0_istek_i || m1_istek_i) && !uart_mesgul_i) begin
               durum_d          = VERI;
               son_kazanan_d    = secilen;
               kazanan_d        = secilen;
               yaz_d            = secilen_yaz;
               wb_adres_d       = secilen_adres;
               wb_veri_d        = secilen_veri;
               wb_gecerli_d     = 1'b1;
               wb_yaz_gecerli_d = secilen_yaz;
               kabul_d[secilen] = 1'b1;
            end
         end
         VERI: begin
            // The controller answers at the end of the strobe cycle; capture it here.
            durum_d            = YANIT;
            bitti_d[kazanan_q] = 1'b1;
            if (!yaz_q && wb_oku_gecerli_i) begin
               oku_gecerli_d[kazanan_q] = 1'b1;
               oku_veri_d[kazanan_q]    = wb_oku_veri_i;
            end
         end
         YANIT: begin
            durum_d = BOSTA;
         end
         default: begin
            durum_d = BOSTA;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         durum_q          <= BOSTA;
         son_kazanan_q    <= 1'b1;
         kazanan_q        <= 1'b0;
         yaz_q            <= 1'b0;
         wb_adres_q       <= '0;
         wb_veri_q        <= '0;
         wb_gecerli_q     <= 1'b0;
         wb_yaz_gecerli_q <= 1'b0;
         kabul_q          <= 2'b00;
         bitti_q          <= 2'b00;
         oku_gecerli_q    <= 2'b00;
         oku_veri_q       <= '0;
      end else begin
         durum_q          <= durum_d;
         son_kazanan_q    <= son_kazanan_d;
         kazanan_q        <= kazanan_d;
         yaz_q            <= yaz_d;
         wb_adres_q       <= wb_adres_d;
         wb_veri_q        <= wb_veri_d;
         wb_gecerli_q     <= wb_gecerli_d;
         wb_yaz_gecerli_q <= wb_yaz_gecerli_d;
         kabul_q          <= kabul_d;
         bitti_q          <= bitti_d;
         oku_gecerli_q    <= oku_gecerli_d;
         oku_veri_q       <= oku_veri_d;
      end
   end

   assign m0_kabul_o       = kabul_q[0];
   assign m1_kabul_o       = kabul_q[1];
   assign m0_bitti_o       = bitti_q[0];
   assign m1_bitti_o       = bitti_q[1];
   assign m0_oku_gecerli_o = oku_gecerli_q[0];
   assign m1_oku_gecerli_o = oku_gecerli_q[1];
   assign m0_oku_veri_o    = oku_veri_q[0];
   assign m1_oku_veri_o    = oku_veri_q[1];
   assign wb_adres_o       = wb_adres_q;
   assign wb_veri_o        = wb_veri_q;
   assign wb_gecerli_o     = wb_gecerli_q;
   assign wb_yaz_gecerli_o = wb_yaz_gecerli_q;

endmodule

// File: tb/tb_uart_erisim_hakemi.sv
// tb/tb_uart_erisim_hakemi.sv - scoreboard bench for uart_erisim_hakemi
`timescale 1ns/1ps
module tb_uart_erisim_hakemi;

   localparam logic [31:0] P_VERI = 32'hC0DE_0001;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        m0_istek_i = 1'b0, m1_istek_i = 1'b0;
   logic        m0_yaz_i = 1'b0, m1_yaz_i = 1'b0;
   logic [31:0] m0_adres_i = '0, m1_adres_i = '0, m0_veri_i = '0, m1_veri_i = '0;
   logic        m0_kabul_o, m1_kabul_o, m0_bitti_o, m1_bitti_o;
   logic        m0_oku_gecerli_o, m1_oku_gecerli_o;
   logic [31:0] m0_oku_veri_o, m1_oku_veri_o, wb_adres_o, wb_veri_o;
   logic        wb_gecerli_o, wb_yaz_gecerli_o;
   logic [31:0] wb_oku_veri_i;
   logic        wb_oku_gecerli_i;
   logic        uart_mesgul_i;

   logic        p_m0_kabul_o, p_m1_kabul_o, p_m0_bitti_o, p_m1_bitti_o;
   logic        p_m0_oku_gecerli_o, p_m1_oku_gecerli_o;
   logic [31:0] p_m0_oku_veri_o, p_m1_oku_veri_o, p_wb_adres_o, p_wb_veri_o;
   logic        p_wb_gecerli_o, p_wb_yaz_gecerli_o;

   logic [31:0] rmem [16];
   bit   [15:0] rvld;
   bit          busy_en = 1'b0, busy_force = 1'b0, rnd_busy = 1'b0;

   typedef struct {
      bit          m;
      bit          yaz;
      logic [31:0] adr;
      logic [31:0] veri;
      logic [31:0] d0;
      logic [31:0] d1;
      bit          vld;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   bit          pend = 1'b0;
   bit          mon_en = 1'b0;
   bit          fix_done = 1'b0;
   logic [31:0] last_adr = '0, last_veri = '0;
   bit          last = 1'b1;
   logic [31:0] ev0 = '0, ev1 = '0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign wb_oku_veri_i    = rmem[wb_adres_o[5:2]];
   assign wb_oku_gecerli_i = rvld[wb_adres_o[5:2]];
   assign uart_mesgul_i    = busy_force | (busy_en & rnd_busy);

   uart_erisim_hakemi dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_istek_i(m0_istek_i), .m1_istek_i(m1_istek_i),
      .m0_yaz_i(m0_yaz_i), .m1_yaz_i(m1_yaz_i),
      .m0_adres_i(m0_adres_i), .m1_adres_i(m1_adres_i),
      .m0_veri_i(m0_veri_i), .m1_veri_i(m1_veri_i),
      .m0_kabul_o(m0_kabul_o), .m1_kabul_o(m1_kabul_o),
      .m0_bitti_o(m0_bitti_o), .m1_bitti_o(m1_bitti_o),
      .m0_oku_gecerli_o(m0_oku_gecerli_o), .m1_oku_gecerli_o(m1_oku_gecerli_o),
      .m0_oku_veri_o(m0_oku_veri_o), .m1_oku_veri_o(m1_oku_veri_o),
      .wb_adres_o(wb_adres_o), .wb_veri_o(wb_veri_o),
      .wb_gecerli_o(wb_gecerli_o), .wb_yaz_gecerli_o(wb_yaz_gecerli_o),
      .wb_oku_veri_i(wb_oku_veri_i), .wb_oku_gecerli_i(wb_oku_gecerli_i),
      .uart_mesgul_i(uart_mesgul_i)
   );

   uart_erisim_hakemi #(.ONCELIK_SABIT(1'b1)) dut_sabit (
      .clk_i(clk), .rst_i(rst_i),
      .m0_istek_i(1'b1), .m1_istek_i(1'b1),
      .m0_yaz_i(1'b1), .m1_yaz_i(1'b1),
      .m0_adres_i(32'h0000_0010), .m1_adres_i(32'h0000_0020),
      .m0_veri_i(P_VERI), .m1_veri_i(32'h0BAD_0002),
      .m0_kabul_o(p_m0_kabul_o), .m1_kabul_o(p_m1_kabul_o),
      .m0_bitti_o(p_m0_bitti_o), .m1_bitti_o(p_m1_bitti_o),
      .m0_oku_gecerli_o(p_m0_oku_gecerli_o), .m1_oku_gecerli_o(p_m1_oku_gecerli_o),
      .m0_oku_veri_o(p_m0_oku_veri_o), .m1_oku_veri_o(p_m1_oku_veri_o),
      .wb_adres_o(p_wb_adres_o), .wb_veri_o(p_wb_veri_o),
      .wb_gecerli_o(p_wb_gecerli_o), .wb_yaz_gecerli_o(p_wb_yaz_gecerli_o),
      .wb_oku_veri_i(32'h0), .wb_oku_gecerli_i(1'b0),
      .uart_mesgul_i(1'b0)
   );

   task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Reference model: expected transaction for master m, including read-data hold.
   task automatic push_txn(input bit m, input bit yaz, input logic [31:0] adr, input logic [31:0] veri);
      exp_t e;
      e.m = m; e.yaz = yaz; e.adr = adr; e.veri = veri; e.vld = 1'b0;
      if (!yaz && rvld[adr[5:2]]) begin
         e.vld = 1'b1;
         if (m) ev1 = rmem[adr[5:2]];
         else   ev0 = rmem[adr[5:2]];
      end
      e.d0 = ev0;
      e.d1 = ev1;
      q.push_back(e);
      last = m;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && (q.size() != 0 || pend); i++) @(negedge clk);
      if (q.size() != 0 || pend) fail_now("idle_timeout");
   endtask

   task automatic run_round(input bit r0, input bit r1, input bit y0, input bit y1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] v0, input logic [31:0] v1, input bit chk_lat);
      bit d0, d1;
      int first_i;
      wait_idle();
      if (r0 && r1) begin
         if (last) begin push_txn(1'b0, y0, a0, v0); push_txn(1'b1, y1, a1, v1); end
         else      begin push_txn(1'b1, y1, a1, v1); push_txn(1'b0, y0, a0, v0); end
      end else if (r0) push_txn(1'b0, y0, a0, v0);
      else             push_txn(1'b1, y1, a1, v1);
      @(posedge clk); #1;
      m0_istek_i = r0; m0_yaz_i = y0; m0_adres_i = a0; m0_veri_i = v0;
      m1_istek_i = r1; m1_yaz_i = y1; m1_adres_i = a1; m1_veri_i = v1;
      d0 = !r0; d1 = !r1; first_i = -1;
      for (int i = 0; i < 200 && !(d0 && d1); i++) begin
         @(negedge clk);
         if ((m0_kabul_o || m1_kabul_o) && first_i < 0) first_i = i;
         if (m0_kabul_o) d0 = 1'b1;
         if (m1_kabul_o) d1 = 1'b1;
         @(posedge clk); #1;
         if (d0) m0_istek_i = 1'b0;
         if (d1) m1_istek_i = 1'b0;
      end
      if (!(d0 && d1)) fail_now("grant_timeout");
      if (chk_lat) chk("kabul_latency", 96'(first_i), 96'(1));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (pend) begin
               chk("bitti", 96'({m1_bitti_o, m0_bitti_o}), 96'(cur.m ? 2'b10 : 2'b01));
               chk("oku_gecerli", 96'({m1_oku_gecerli_o, m0_oku_gecerli_o}),
                   96'(cur.vld ? (cur.m ? 2'b10 : 2'b01) : 2'b00));
               chk("oku_veri", 96'({m1_oku_veri_o, m0_oku_veri_o}), 96'({cur.d1, cur.d0}));
               chk("yanit_quiet", 96'({m1_kabul_o, m0_kabul_o, wb_gecerli_o, wb_yaz_gecerli_o}), 96'(0));
               pend = 1'b0;
            end else if (m0_kabul_o || m1_kabul_o) begin
               if (q.size() == 0) begin
                  fail_now("unexpected_kabul");
               end else begin
                  cur = q.pop_front();
                  chk("kabul", 96'({m1_kabul_o, m0_kabul_o}), 96'(cur.m ? 2'b10 : 2'b01));
                  chk("wb_strobe", 96'({wb_gecerli_o, wb_yaz_gecerli_o, m1_bitti_o, m0_bitti_o}),
                      96'({1'b1, cur.yaz, 2'b00}));
                  chk("wb_adres_veri", 96'({wb_adres_o, wb_veri_o}), 96'({cur.adr, cur.veri}));
                  last_adr  = cur.adr;
                  last_veri = cur.veri;
                  pend = 1'b1;
               end
            end else begin
               chk("idle", 96'({wb_gecerli_o, wb_yaz_gecerli_o, m1_bitti_o, m0_bitti_o,
                                m1_oku_gecerli_o, m0_oku_gecerli_o, wb_adres_o, wb_veri_o}),
                   96'({6'b0, last_adr, last_veri}));
            end
         end
      end
   end

   always @(posedge clk) rnd_busy <= ($urandom_range(3) == 0);

   // Fixed-priority instance: both masters request permanently, m0 must take every grant.
   initial begin
      int n = 0;
      bit pg = 1'b0;
      wait (rst_i === 1'b1);
      for (int i = 0; i < 60 && (n < 4 || pg); i++) begin
         @(negedge clk);
         if (pg) begin
            chk("fix_bitti", 96'({p_m1_bitti_o, p_m0_bitti_o, p_m1_oku_gecerli_o, p_m0_oku_gecerli_o,
                                  p_m1_oku_veri_o, p_m0_oku_veri_o}), 96'({4'b0100, 64'd0}));
            pg = 1'b0;
         end else if (p_m0_kabul_o || p_m1_kabul_o) begin
            chk("fix_grant", 96'({p_m1_kabul_o, p_m0_kabul_o, p_wb_gecerli_o, p_wb_yaz_gecerli_o,
                                  p_wb_adres_o, p_wb_veri_o}), 96'({4'b0111, 32'h0000_0010, P_VERI}));
            n++;
            pg = 1'b1;
         end
      end
      if (n < 4) fail_now("fix_grant_timeout");
      fix_done = 1'b1;
   end

   initial begin
      logic [1:0]  mask;
      logic [31:0] a0, a1;
      for (int i = 0; i < 16; i++) begin
         rmem[i] = $urandom;
         rvld[i] = 1'($urandom);
      end
      rmem[1] = 32'h0000_000C; rvld[1] = 1'b1;
      rvld[2] = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_pulses", 96'({m1_kabul_o, m0_kabul_o, m1_bitti_o, m0_bitti_o, m1_oku_gecerli_o,
                             m0_oku_gecerli_o, wb_gecerli_o, wb_yaz_gecerli_o}), 96'(0));
      chk("rst_wb_adres", 96'(wb_adres_o), 96'(0));
      chk("rst_wb_veri", 96'(wb_veri_o), 96'(0));
      chk("rst_oku_veri", 96'({m1_oku_veri_o, m0_oku_veri_o}), 96'(0));
      @(posedge clk); #1;
      rst_i = 1'b1;
      mon_en = 1'b1;

      run_round(1, 1, 1, 1, 32'h100, 32'h104, 32'h1111_0000, 32'h2222_0000, 1'b1);
      run_round(1, 1, 1, 1, 32'h108, 32'h10C, 32'h3333_0000, 32'h4444_0000, 1'b1);
      run_round(1, 0, 1, 0, 32'h0, 32'h0, 32'h00A0_0003, 32'h0, 1'b1);
      run_round(0, 1, 0, 0, 32'h0, 32'h4, 32'h0, 32'h0, 1'b1);
      run_round(1, 0, 0, 0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b1);
      run_round(1, 0, 0, 0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b1);

      wait_idle();
      @(posedge clk); #1;
      busy_force = 1'b1;
      push_txn(1'b1, 1'b0, 32'h4, 32'h0);
      m1_istek_i = 1'b1; m1_yaz_i = 1'b0; m1_adres_i = 32'h4;
      repeat (5) begin
         @(negedge clk);
         chk("busy_hold", 96'({m1_kabul_o, m0_kabul_o, wb_gecerli_o}), 96'(0));
      end
      @(posedge clk); #1;
      busy_force = 1'b0;
      @(negedge clk);
      chk("busy_fall_1", 96'({m1_kabul_o, wb_gecerli_o}), 96'(0));
      @(negedge clk);
      chk("busy_fall_2", 96'({m1_kabul_o, wb_gecerli_o}), 96'(2'b11));
      @(posedge clk); #1;
      m1_istek_i = 1'b0;

      busy_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         mask = 2'($urandom_range(3, 1));
         a0 = $urandom; a1 = $urandom;
         run_round(mask[0], mask[1], 1'($urandom), 1'($urandom), a0, a1, $urandom, $urandom, 1'b0);
      end
      busy_en = 1'b0;

      wait_idle();
      mon_en = 1'b0;
      @(posedge clk); #1;
      m0_istek_i = 1'b1; m0_yaz_i = 1'b1; m0_adres_i = 32'h10; m0_veri_i = 32'h5555_AAAA;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_kabul", 96'({m0_kabul_o, wb_gecerli_o}), 96'(2'b11));
      #1 rst_i = 1'b0;
      #1 chk("async_drop", 96'({m1_kabul_o, m0_kabul_o, wb_gecerli_o, wb_yaz_gecerli_o}), 96'(0));
      m0_istek_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_bitti_after_reset", 96'({m1_bitti_o, m0_bitti_o, m1_kabul_o, m0_kabul_o}), 96'(0));
      end
      last = 1'b1; ev0 = '0; ev1 = '0; last_adr = '0; last_veri = '0;
      mon_en = 1'b1;
      run_round(1, 1, 0, 1, 32'h4, 32'h14, 32'h0, 32'h6666_0000, 1'b1);

      wait_idle();
      for (int i = 0; i < 200 && !fix_done; i++) @(negedge clk);
      if (!fix_done) fail_now("fix_done_timeout");
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
